add_2_parts_arb: RTL and testbench
==================================

# add_2_parts_arb

Round-robin arbiter and sequencer that shares one `add_2_parts` two-stage adder between `NREQ` requesters, such as point-arithmetic units in the EdDSA datapath. It accepts one operation at a time and latches the winner's operands. It drives the adder's start/operand handshake, waits for completion, and returns the `SIZE+1`-bit sum to the owning requester with a one-cycle response strobe.

## Interface
- `SIZE`, 224, operand width; must be even; matches the shared adder.
- `NREQ`, 4, number of requesters, ≥2.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset; also resets the shared adder.
- `req`  in  NREQ  per-requester request; held with operands until its `gnt` pulse.
- `op_a`  in  NREQ*SIZE  packed operand A; requester i occupies bits [i*SIZE +: SIZE].
- `op_b`  in  NREQ*SIZE  packed operand B, same packing.
- `gnt`  out  NREQ  one-hot, one-cycle pulse: request accepted, operands latched.
- `rsp_valid`  out  NREQ  one-hot, one-cycle pulse: `rsp_result` valid for that requester.
- `rsp_result`  out  SIZE+1  shared result register; holds its value until the next completion.
- `busy`  out  1  high in any state other than IDLE.
- `add_start`  out  1  start to the adder.
- `add_a`, `add_b`  out  SIZE each  latched operands; stable from grant until return to IDLE.
- `add_result`  in  SIZE+1  adder result.
- `add_done`  in  1  adder done. It is high when the adder is idle and low for exactly one cycle after `add_start` is accepted.

## Operation
- State machine: IDLE → START → WAIT_LO → WAIT_HI → IDLE.
- **IDLE:**
  - If any `req` bit is set, arbitrate and pick winner w.
  - Register `gnt[w]`=1 for one cycle and latch `op_a`/`op_b` slice w into `add_a`/`add_b`.
  - Store owner=w, then go to START.
  - If no `req` bit is set, stay in IDLE.
- **START:** `add_start`=1 for this cycle only; go to WAIT_LO.
- **WAIT_LO:** stay until `add_done`=0, then go to WAIT_HI.
- **WAIT_HI:** stay until `add_done`=1, then:
  - `rsp_result` ← `add_result`.
  - `rsp_valid[owner]`=1 for one cycle.
  - Go to IDLE.
- Arbitration:
  - Round-robin pointer p, reset to 0.
  - The winner is the first set `req` bit searching p, p+1, …, NREQ-1, 0, … (wraps around).
  - After a grant, p ← w+1 mod NREQ.
- `req` is ignored in every state except IDLE. Requests that arrive while busy wait; nothing is queued.
- Arithmetic: result = `add_a` + `add_b`, zero-extended to SIZE+1; the carry lands in the MSB. There is no modular reduction.
- Reset:
  - All outputs, `add_a`, `add_b`, p and owner go to 0; state goes to IDLE.
  - A reset during an operation abandons it; no `rsp_valid` is issued.

## Timing
- E0 = the edge at which IDLE samples `req`.
- `gnt` is high in cycle E0–E1; `add_start` is high E1–E2.
- The adder drops `add_done` E2–E3 and raises it again at E3.
- WAIT_HI sees `add_done`=1 at edge E4, so `rsp_valid` is high E4–E5.
- Latency from request sampled to `rsp_valid` is 4 cycles.
- IDLE can sample again at E5, so the throughput is one operation per 5 cycles.
- `rsp_valid` and `gnt` never assert in the same cycle.
- A requester re-asserting `req` during its own `rsp_valid` cycle is sampled at the next edge, subject to arbitration.
- `rsp_result` is unchanged between completions.

## Configuration
- `ADD_2_PARTS_ARB_RR_EN`:
  - Defined: round-robin arbitration as specified above.
  - Undefined: fixed priority, where the lowest set `req` index wins; pointer p is not implemented.
- All other behaviour and timing are identical in both builds.

## Test plan
- Single request, SIZE=8: requester 2 sends a=0x35, b=0x4A → `gnt`=4'b0100 one cycle later; `rsp_valid`=4'b0100 4 cycles after sampling; `rsp_result`=0x07F.
- Carry: a=0xFF, b=0xFF → `rsp_result`=0x1FE; a=0x00, b=0x00 → 0x000.
- Contention with RR on: `req`=4'b1111 held → grants in order 0,1,2,3,0, one every 5 cycles; each `rsp_valid` matches its `gnt` index.
- Contention with RR off: `req`=4'b0011 held → every grant goes to requester 0; requester 1 is never granted.
- Reset in WAIT_HI: assert `rst` for one cycle → no `rsp_valid`; all outputs 0; `busy`=0. A subsequent request still completes in 4 cycles.
- Request while busy: requester 1 asserts `req` during requester 0's operation → it is granted only at the first IDLE edge after `rsp_valid[0]`, and gets its correct sum.

Source files
------------

// File: rtl/add_2_parts_arb_if.sv
// Bundle of every signal between the add_2_parts_arb sequencer, its requesters and the shared
// add_2_parts adder. The arbiter takes the slave view; the requester/adder side takes master.
//
// Parameters:
//   SIZE        operand width (even), matches the shared adder
//   NREQ        number of requesters (>= 2)
// Signals:
//   req         per-requester request, held with its operands until gnt
//   op_a, op_b  packed operands, requester i in bits [i*SIZE +: SIZE]
//   gnt         one-hot, one-cycle grant pulse
//   rsp_valid   one-hot, one-cycle completion pulse for the owning requester
//   rsp_result  SIZE+1-bit sum, held until the next completion
//   busy        arbiter not idle
//   add_start   one-cycle start to the adder
//   add_a/add_b latched operands presented to the adder
//   add_result  adder sum
//   add_done    adder idle/done flag, low for one cycle after a start
interface add_2_parts_arb_if #(
    parameter int unsigned SIZE = 224,
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ*SIZE-1:0] op_a;
    logic [NREQ*SIZE-1:0] op_b;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rsp_valid;
    logic [SIZE:0]        rsp_result;
    logic                 busy;
    logic                 add_start;
    logic [SIZE-1:0]      add_a;
    logic [SIZE-1:0]      add_b;
    logic [SIZE:0]        add_result;
    logic                 add_done;

    modport slave (
        input  req, op_a, op_b, add_result, add_done,
        output gnt, rsp_valid, rsp_result, busy, add_start, add_a, add_b
    );

    modport master (
        output req, op_a, op_b, add_result, add_done,
        input  gnt, rsp_valid, rsp_result, busy, add_start, add_a, add_b
    );
endinterface

// File: rtl/add_2_parts_arb.sv
// Arbiter/sequencer sharing one add_2_parts two-stage adder between NREQ requesters.
// One operation at a time: grant and latch the winner's operands, pulse add_start, wait for
// add_done to fall and rise again, then return the SIZE+1-bit sum with a one-cycle rsp_valid.
//
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset (abandons any operation in flight)
//   arb_io  add_2_parts_arb_if slave view: requester handshake, response and adder handshake
//
// Build option:
//   ADD_2_PARTS_ARB_RR_EN  defined: round-robin arbitration with a rotating pointer.
//                          undefined: fixed priority, lowest requesting index wins.
module add_2_parts_arb #(
    parameter int unsigned SIZE = 224,
    parameter int unsigned NREQ = 4
) (
    input logic             clk,
    input logic             rst,
    add_2_parts_arb_if.slave arb_io
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StWaitLo, StWaitHi} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [SIZE:0]   rsp_result_q, rsp_result_d;
    logic            add_start_q, add_start_d;
    logic [SIZE-1:0] add_a_q, add_a_d;
    logic [SIZE-1:0] add_b_q, add_b_d;
    logic [IdxW-1:0] owner_q, owner_d;

    logic            win_found;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] cand_idx;

`ifdef ADD_2_PARTS_ARB_RR_EN
    logic [IdxW-1:0] ptr_q, ptr_d;
`endif

    // Winner search: first set req starting at the pointer (or at 0 for fixed priority).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef ADD_2_PARTS_ARB_RR_EN
            cand_idx = IdxW'((32'(ptr_q) + i) % NREQ);
`else
            cand_idx = IdxW'(i);
`endif
            if (!win_found && arb_io.req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = '0;
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        add_start_d  = 1'b0;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        owner_d      = owner_q;
`ifdef ADD_2_PARTS_ARB_RR_EN
        ptr_d        = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d[win_idx] = 1'b1;
                    add_a_d        = arb_io.op_a[win_idx*SIZE +: SIZE];
                    add_b_d        = arb_io.op_b[win_idx*SIZE +: SIZE];
                    owner_d        = win_idx;
`ifdef ADD_2_PARTS_ARB_RR_EN
                    ptr_d = (win_idx == IdxW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                    state_d = StStart;
                end
            end
            StStart: begin
                // Registered, so add_start is seen high in the cycle after this state.
                add_start_d = 1'b1;
                state_d     = StWaitLo;
            end
            StWaitLo: begin
                if (!arb_io.add_done) begin
                    state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                if (arb_io.add_done) begin
                    rsp_result_d         = arb_io.add_result;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            add_start_q  <= 1'b0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            owner_q      <= '0;
`ifdef ADD_2_PARTS_ARB_RR_EN
            ptr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            add_start_q  <= add_start_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            owner_q      <= owner_d;
`ifdef ADD_2_PARTS_ARB_RR_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign arb_io.gnt        = gnt_q;
    assign arb_io.rsp_valid  = rsp_valid_q;
    assign arb_io.rsp_result = rsp_result_q;
    assign arb_io.busy       = (state_q != StIdle);
    assign arb_io.add_start  = add_start_q;
    assign arb_io.add_a      = add_a_q;
    assign arb_io.add_b      = add_b_q;
endmodule

// File: tb/tb_add_2_parts_arb.sv
// Self-checking bench for add_2_parts_arb (SIZE=8, NREQ=4) with a behavioural adder model and
// a cycle-count reference model of the arbiter.
module tb_add_2_parts_arb;
    localparam int unsigned SIZE = 8;
    localparam int unsigned NREQ = 4;
`ifdef ADD_2_PARTS_ARB_RR_EN
    localparam bit RrOn = 1'b1;
`else
    localparam bit RrOn = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_v;
    logic [NREQ*SIZE-1:0] opa_v;
    logic [NREQ*SIZE-1:0] opb_v;
    logic                 add_done_q;
    logic [SIZE:0]        add_res_q;

    always #5 clk = ~clk;

    add_2_parts_arb_if #(.SIZE(SIZE), .NREQ(NREQ)) bus ();

    assign bus.req        = req_v;
    assign bus.op_a       = opa_v;
    assign bus.op_b       = opb_v;
    assign bus.add_result = add_res_q;
    assign bus.add_done   = add_done_q;

    add_2_parts_arb #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_io (bus)
    );

    // Shared adder: done drops for one cycle after an accepted start, shows junk while low.
    always @(posedge clk) begin
        if (rst) begin
            add_done_q <= 1'b1;
            add_res_q  <= '0;
        end else if (add_done_q && bus.add_start) begin
            add_done_q <= 1'b0;
            add_res_q  <= ~({1'b0, bus.add_a} + {1'b0, bus.add_b});
        end else if (!add_done_q) begin
            add_done_q <= 1'b1;
            add_res_q  <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
        end
    end

    // Reference model state: cnt counts cycles left in the current operation (0 = idle).
    int              cnt, owner, ptr, cyc;
    logic [NREQ-1:0] exp_gnt, exp_rsp;
    logic [SIZE:0]   exp_res, exp_sum;
    logic [SIZE-1:0] exp_a, exp_b;
    int              npass, ntotal;
    int              gnt_log[$];
    int              ord_a[5], ord_b[5];

    typedef struct {
        int            r;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic [SIZE:0]   res;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act !== exp) $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        else npass++;
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return 0;
    endfunction

    // One clock: advance the model on the inputs the DUT sampled, then compare every output.
    task automatic step();
        int  w;
        bool_found: begin end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            cnt = 0; ptr = 0; owner = 0;
            exp_gnt = '0; exp_rsp = '0; exp_res = '0; exp_sum = '0; exp_a = '0; exp_b = '0;
        end else begin
            exp_gnt = '0;
            exp_rsp = '0;
            if (cnt == 0) begin
                if (req_v != '0) begin
                    w = pick(req_v, RrOn ? ptr : 0);
                    exp_gnt[w] = 1'b1;
                    owner = w;
                    exp_a = opa_v[w*SIZE +: SIZE];
                    exp_b = opb_v[w*SIZE +: SIZE];
                    exp_sum = {1'b0, exp_a} + {1'b0, exp_b};
                    ptr = (w + 1) % NREQ;
                    cnt = 4;
                end
            end else begin
                cnt--;
                if (cnt == 0) begin
                    exp_rsp[owner] = 1'b1;
                    exp_res = exp_sum;
                end
            end
        end
        check("gnt", bus.gnt, exp_gnt);
        check("rsp_valid", bus.rsp_valid, exp_rsp);
        check("rsp_result", bus.rsp_result, exp_res);
        check("busy", bus.busy, cnt != 0);
        check("add_start", bus.add_start, cnt == 3);
        if (rst || cnt != 0) begin
            check("add_a", bus.add_a, exp_a);
            check("add_b", bus.add_b, exp_b);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i]) begin
                gnt_log.push_back(i);
                break;
            end
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic single(input int r, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input logic [SIZE:0] exp);
        int lat;
        bit got;
        req_v = '0;
        req_v[r] = 1'b1;
        opa_v[r*SIZE +: SIZE] = a;
        opb_v[r*SIZE +: SIZE] = b;
        step();
        check("single_gnt", bus.gnt, 1 << r);
        req_v[r] = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 10 && !got; k++) begin
            step();
            if (bus.rsp_valid != '0) begin
                got = 1'b1;
                lat = k;
            end
        end
        check("single_latency", lat, 4);
        check("single_rsp_valid", bus.rsp_valid, 1 << r);
        check("single_result", bus.rsp_result, exp);
        step();
        check("single_result_hold", bus.rsp_result, exp);
    endtask

    task automatic contention(input logic [NREQ-1:0] pattern, input int ord[5], input string tag);
        reset_pulse();
        for (int i = 0; i < NREQ; i++) begin
            opa_v[i*SIZE +: SIZE] = SIZE'(37 * i + 19);
            opb_v[i*SIZE +: SIZE] = SIZE'(200 - 11 * i);
        end
        gnt_log.delete();
        req_v = pattern;
        repeat (25) step();
        req_v = '0;
        repeat (6) step();
        check({tag, "_ngrants"}, gnt_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("%s_grant%0d", tag, k), (k < gnt_log.size()) ? gnt_log[k] : -1,
                  ord[k]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp0, g1;
        npass = 0; ntotal = 0; cyc = 0;
        cnt = 0; ptr = 0; owner = 0;
        exp_gnt = '0; exp_rsp = '0; exp_res = '0; exp_sum = '0; exp_a = '0; exp_b = '0;
        rst = 1'b1;
        req_v = '0;
        opa_v = '0;
        opb_v = '0;
        step();
        step();
        rst = 1'b0;
        step();

        vecs[0] = '{2, 8'h35, 8'h4A, 9'h07F};
        vecs[1] = '{0, 8'hFF, 8'hFF, 9'h1FE};
        vecs[2] = '{1, 8'h00, 8'h00, 9'h000};
        vecs[3] = '{3, 8'h80, 8'h80, 9'h100};
        vecs[4] = '{0, 8'h01, 8'hFE, 9'h0FF};
        vecs[5] = '{3, 8'hAA, 8'h56, 9'h100};
        for (int i = 0; i < 6; i++) single(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].res);

`ifdef ADD_2_PARTS_ARB_RR_EN
        ord_a = '{0, 1, 2, 3, 0};
        ord_b = '{0, 1, 0, 1, 0};
`else
        ord_a = '{0, 0, 0, 0, 0};
        ord_b = '{0, 0, 0, 0, 0};
`endif
        contention(4'b1111, ord_a, "all4");
        contention(4'b0011, ord_b, "low2");

        // Reset while waiting for the adder's second phase.
        req_v = 4'b0001;
        opa_v[0 +: SIZE] = 8'h12;
        opb_v[0 +: SIZE] = 8'h34;
        step();
        req_v = '0;
        repeat (3) step();
        rst = 1'b1;
        step();
        check("rstmid_rsp_valid", bus.rsp_valid, 0);
        check("rstmid_busy", bus.busy, 0);
        check("rstmid_rsp_result", bus.rsp_result, 0);
        check("rstmid_add_a", bus.add_a, 0);
        rst = 1'b0;
        single(1, 8'h3C, 8'hC4, 9'h100);

        // Requester 1 arrives while requester 0 is in flight.
        req_v = 4'b0001;
        opa_v[0 +: SIZE] = 8'h77;
        opb_v[0 +: SIZE] = 8'h11;
        step();
        req_v = '0;
        step();
        req_v[1] = 1'b1;
        opa_v[SIZE +: SIZE] = 8'h90;
        opb_v[SIZE +: SIZE] = 8'h90;
        rsp0 = -100;
        g1 = -1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.rsp_valid[0]) rsp0 = cyc;
            if (bus.gnt[1]) begin
                g1 = cyc;
                req_v[1] = 1'b0;
            end
        end
        check("busy_req_gap", g1 - rsp0, 1);

        // Random traffic with occasional resets.
        for (int t = 0; t < 600; t++) begin
            rst = ($urandom_range(0, 149) == 0);
            step();
            rst = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (exp_gnt[i]) begin
                    req_v[i] = 1'b0;
                end else if (!req_v[i] && $urandom_range(0, 3) == 0) begin
                    req_v[i] = 1'b1;
                    opa_v[i*SIZE +: SIZE] = SIZE'($urandom);
                    opb_v[i*SIZE +: SIZE] = SIZE'($urandom);
                end
            end
        end
        req_v = '0;
        repeat (6) step();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
